eco_patch_lut: RTL
==================

// Module: eco_patch_lut
// PURPOSE
//  Programmable ECO patch stage that sits on the output of a frozen netlist core.
//  It takes the core's inputs A/B and its unpatched result base_y, and registers them.
//  It then XORs base_y with flip masks taken from DEPTH match entries (care/match on {B,A}).
//  Entries are loaded into a shadow table and made active through a drain-then-commit
//  handshake, so a netlist bug can be patched in-field without a respin.
// PARAMETERS
//  IN_W   5   width of each operand A and B
//  OUT_W  3   width of base_y / Y
//  DEPTH  4   number of patch entries (>=1)
//  CNT_W  16  width of saturating hit counter
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 synchronous, active-high reset
//  in_valid   in   1                 operand beat valid
//  in_ready   out  1                 operand beat accepted when in_valid&in_ready
//  A          in   IN_W              operand A
//  B          in   IN_W              operand B
//  base_y     in   OUT_W             unpatched core output for this A/B
//  out_valid  out  1                 Y valid (one cycle per accepted beat)
//  Y          out  OUT_W             patched output
//  out_hit    out  1                 >=1 active entry matched this beat
//  cfg_we     in   1                 shadow-entry write strobe
//  cfg_we_rdy out  1                 write accepted when cfg_we&cfg_we_rdy
//  cfg_idx    in   $clog2(DEPTH)     entry index (idx>=DEPTH: write ignored)
//  cfg_en     in   1                 entry enable
//  cfg_care   in   2*IN_W            care mask over {B,A}
//  cfg_match  in   2*IN_W            match value over {B,A}
//  cfg_flip   in   OUT_W             bits of Y inverted on hit
//  cfg_commit in   1                 request shadow->active copy (pulse, IDLE only)
//  cfg_done   out  1                 one-cycle pulse: active table updated
//  hit_cnt    out  CNT_W             count of out_valid beats with out_hit, saturating
// BEHAVIOUR
//  Reset: shadow+active entries en=0 (Y==base_y); state IDLE; in_ready=1, cfg_we_rdy=1;
//   out_valid=0, Y=0, out_hit=0, cfg_done=0, hit_cnt=0. Reset mid-commit aborts; active table cleared.
//  Pipeline, latency 2: S1 registers {A,B,base_y,valid} on accept; S2 registers the result.
//   S2: hit[i] = en[i] & ((({B,A}^match[i]) & care[i]) == 0); flip = OR of flip[i] over hits.
//   Y = base_y ^ flip; out_hit = |hit. Multiple hits OR their flips; no priority.
//   care==0 with en=1 matches every beat. No backpressure on output.
//  FSM (state registered, drives in_ready/cfg_we_rdy):
//   IDLE : in_ready=1, cfg_we_rdy=1; cfg_commit -> DRAIN (beat accepted same cycle still flows).
//   DRAIN: in_ready=0, cfg_we_rdy=0; when S1.valid==0 && S2.valid==0 -> COPY.
//   COPY : active<=shadow, cfg_done=1, in_ready=0 -> IDLE. The new table applies to beats accepted from IDLE on.
//   Min commit: commit@t, DRAIN@t+1, COPY@t+2 (cfg_done high), IDLE@t+3.
//   A beat accepted at t completes out_valid@t+2, so COPY is reached at t+3 or later.
//  cfg_commit outside IDLE ignored. cfg_we and cfg_commit in the same IDLE cycle: the write lands in shadow
//   and is included in the copy. Shadow is persistent; commit copies all DEPTH entries.
//  hit_cnt += 1 per out_valid&out_hit; holds at 2**CNT_W-1.
// STRUCTURE
//  eco_pkg: typedef eco_entry_t {en,care,match,flip} (parametrised via macros/localparams),
//   enum eco_state_t {IDLE,DRAIN,COPY}, localparam CNT_MAX.
//  Sub-module eco_patch_match: one entry compare -> hit, flip&{OUT_W{hit}}; generate DEPTH instances.
// TESTING
//  1 Reset, no commit: A=5'h08,B=5'h01,base_y=3'b101 @t -> out_valid@t+2, Y=3'b101, out_hit=0.
//  2 Entry0 {en=1,care=10'h3FF,match={B=5'h01,A=5'h08},flip=3'b100}, commit -> cfg_done 2 cycles later; same beat -> Y=3'b001, hit_cnt=1.
//  3 Entries 0,1 care=0, flip 3'b001/3'b010, commit; base_y=0 -> Y=3'b011 every beat (OR).
//  4 Back-to-back beats @t,t+1 then commit@t+1 -> in_ready=0 @t+2..COPY; both beats use the old table; cfg_done once.
//  5 cfg_commit asserted during DRAIN, cfg_we in DRAIN -> ignored (cfg_we_rdy=0); exactly one cfg_done.
//  6 CNT_W=2, 5 hitting beats -> hit_cnt 1,2,3,3,3; rst asserted in DRAIN -> IDLE, Y==base_y next beat.

Source files
------------

// File: rtl/eco_pkg.sv
// Shared types for the ECO patch stage: entry record, controller states and
// the default widths the entry record is built from.
package eco_pkg;

  localparam int ECO_IN_W  = 5;
  localparam int ECO_OUT_W = 3;
  localparam int ECO_KEY_W = 2 * ECO_IN_W;
  localparam int ECO_CNT_W = 16;

  localparam logic [ECO_CNT_W-1:0] CNT_MAX = '1;

  // Care/match operate on the concatenated key {B, A}.
  typedef struct packed {
    logic                 en;
    logic [ECO_KEY_W-1:0] care;
    logic [ECO_KEY_W-1:0] match;
    logic [ECO_OUT_W-1:0] flip;
  } eco_entry_t;

  localparam eco_entry_t ENTRY_OFF = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    COPY  = 2'd2
  } eco_state_t;

endpackage

// File: rtl/eco_patch_match.sv
// Single patch-entry comparator: masked key compare and gated flip mask.
module eco_patch_match #(
  parameter int KEY_W = 10,
  parameter int OUT_W = 3
) (
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_en,
  input  logic [KEY_W-1:0] i_care,
  input  logic [KEY_W-1:0] i_match,
  input  logic [OUT_W-1:0] i_flip,
  output logic             o_hit,
  output logic [OUT_W-1:0] o_flip
);

  // Hit when every cared-about key bit equals the match value; care==0 always hits.
  always_comb begin
    o_hit  = i_en & (((i_key ^ i_match) & i_care) == '0);
    o_flip = i_flip & {OUT_W{o_hit}};
  end

endmodule

// File: rtl/eco_patch_lut.sv
// ECO patch stage: two-stage pipeline that XORs the frozen core's result with
// flip masks from matching entries. The table is written into a shadow copy and
// only made active once the pipeline has drained, so no beat ever sees a mix of
// old and new entries.
//
// state | meaning
// IDLE  | accepting beats and config writes; commit request moves to DRAIN
// DRAIN | input and config stalled, waiting for S1 and S2 to empty
// COPY  | shadow copied into active table, cfg_done pulsed
module eco_patch_lut
  import eco_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = ECO_CNT_W,
  // Operand/output widths are tied to the entry record in eco_pkg.
  localparam int IN_W  = ECO_IN_W,
  localparam int OUT_W = ECO_OUT_W,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    A,
  input  logic [IN_W-1:0]    B,
  input  logic [OUT_W-1:0]   base_y,
  output logic               out_valid,
  output logic [OUT_W-1:0]   Y,
  output logic               out_hit,
  input  logic               cfg_we,
  output logic               cfg_we_rdy,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [2*IN_W-1:0]  cfg_care,
  input  logic [2*IN_W-1:0]  cfg_match,
  input  logic [OUT_W-1:0]   cfg_flip,
  input  logic               cfg_commit,
  output logic               cfg_done,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

  eco_state_t r_state;
  eco_state_t w_state_nxt;
  logic       w_in_ready;
  logic       w_we_rdy;
  logic       w_done;

  eco_entry_t r_shadow [DEPTH];
  eco_entry_t r_active [DEPTH];

  logic             r_s1_valid;
  logic [IN_W-1:0]  r_s1_a;
  logic [IN_W-1:0]  r_s1_b;
  logic [OUT_W-1:0] r_s1_base;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_y;
  logic             r_hit;
  logic [CNT_W-1:0] r_hit_cnt;

  logic             w_accept;
  logic             w_cfg_wr;
  logic [DEPTH-1:0] w_hit;
  logic [OUT_W-1:0] w_flip_vec [DEPTH];
  logic [OUT_W-1:0] w_flip;
  logic             w_any_hit;

  assign w_accept = in_valid & w_in_ready;
  assign w_cfg_wr = cfg_we & w_we_rdy & (int'(cfg_idx) < DEPTH);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs, all decoded from the registered state.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_we_rdy    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_we_rdy   = 1'b1;
        if (cfg_commit) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_s1_valid && !r_out_valid) w_state_nxt = COPY;
      end
      COPY: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shadow table takes config writes; active table is loaded only in COPY.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_shadow[i] <= ENTRY_OFF;
        r_active[i] <= ENTRY_OFF;
      end
    end else begin
      if (w_cfg_wr) begin
        r_shadow[cfg_idx] <= '{en: cfg_en, care: cfg_care, match: cfg_match, flip: cfg_flip};
      end
      if (r_state == COPY) begin
        for (int i = 0; i < DEPTH; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  // Stage 1: capture operands and core result on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_base  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a    <= A;
        r_s1_b    <= B;
        r_s1_base <= base_y;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    eco_patch_match #(
      .KEY_W (2 * IN_W),
      .OUT_W (OUT_W)
    ) u_match (
      .i_key   ({r_s1_b, r_s1_a}),
      .i_en    (r_active[g].en),
      .i_care  (r_active[g].care),
      .i_match (r_active[g].match),
      .i_flip  (r_active[g].flip),
      .o_hit   (w_hit[g]),
      .o_flip  (w_flip_vec[g])
    );
  end

  // Overlapping entries combine by OR; there is no priority between entries.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < DEPTH; i++) w_flip = w_flip | w_flip_vec[i];
    w_any_hit = |w_hit;
  end

  // Stage 2: patched result; Y holds its last value between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_hit       <= r_s1_valid & w_any_hit;
      if (r_s1_valid) r_y <= r_s1_base ^ w_flip;
    end
  end

  // Saturating count of patched output beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt <= '0;
    end else if (r_out_valid && r_hit && (r_hit_cnt != L_CNT_MAX)) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign in_ready   = w_in_ready;
  assign cfg_we_rdy = w_we_rdy;
  assign cfg_done   = w_done;
  assign out_valid  = r_out_valid;
  assign Y          = r_y;
  assign out_hit    = r_hit;
  assign hit_cnt    = r_hit_cnt;

endmodule
